// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Exhaustive stimulus engine for small combinational blocks
//            (K-map / logic-minimisation exercises). On start it walks every
//            input code 0 .. 2^IN_W-1, holds each code for SETTLE cycles,
//            then compares the DUT response with the golden-model output
//            for that code. It reports the mismatch count, the first failing
//            code and a sticky done flag.
//
// Parameters:
//   IN_W    - DUT input width; the sweep covers 2^IN_W codes
//   OUT_W   - DUT output width (>= 2, needed by the signature rotate)
//   SETTLE  - cycles each code is held before it is checked (1..15)
//
// Ports:
//   clk             in   1        clock, rising edge
//   rst             in   1        synchronous active-high reset
//   start           in   1        sweep request, honoured only in IDLE/DONE
//   stim            out  IN_W     code driven to the DUT and golden model
//   resp            in   OUT_W    DUT output for stim
//   exp             in   OUT_W    golden-model output for stim
//   busy            out  1        sweep in progress
//   done            out  1        sweep complete, held until start or rst
//   err_cnt         out  IN_W+1   number of mismatching codes
//   first_err_idx   out  IN_W     code of the first mismatch
//   first_err_valid out  1        first_err_idx is meaningful
//   sig             out  OUT_W    response signature (0 when disabled)
//
// Build option:
//   SWEEP_SIGNATURE_EN - when defined, a rotate-XOR signature of every
//                        sampled response is accumulated on sig. When
//                        undefined there is no signature register and sig
//                        is tied to 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IN_W-1:0]   stim,
    input  logic [OUT_W-1:0]  resp,
    input  logic [OUT_W-1:0]  exp,
    output logic              busy,
    output logic              done,
    output logic [IN_W:0]     err_cnt,
    output logic [IN_W-1:0]   first_err_idx,
    output logic              first_err_valid,
    output logic [OUT_W-1:0]  sig
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Last code of the sweep; reaching it in CHECK ends the sweep instead
    // of incrementing, so stim never wraps back to 0 mid-sweep.
    localparam logic [IN_W-1:0] c_max_code   = {IN_W{1'b1}};
    // The settle counter is loaded with SETTLE-1 and APPLY exits when it
    // reads 0, giving exactly SETTLE cycles in APPLY.
    localparam logic [3:0]      c_settle_ld  = 4'(SETTLE - 1);
    localparam logic [IN_W-1:0] c_stim_one   = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W:0]   c_err_one    = {{IN_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state;

    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt;
    logic [IN_W-1:0]   r_stim;
    logic [IN_W-1:0]   w_stim;
    logic              r_busy;
    logic              w_busy;
    logic              r_done;
    logic              w_done;
    logic [IN_W:0]     r_err_cnt;
    logic [IN_W:0]     w_err_cnt;
    logic [IN_W-1:0]   r_first_idx;
    logic [IN_W-1:0]   w_first_idx;
    logic              r_first_valid;
    logic              w_first_valid;

    // Compare result for the code currently being checked. Only consumed
    // on the CHECK-exit edge, so resp/exp reach outputs only via registers.
    logic              w_mismatch;
    assign w_mismatch = (resp != exp);

`ifdef SWEEP_SIGNATURE_EN
    logic [OUT_W-1:0]  r_sig;
    logic [OUT_W-1:0]  w_sig;
    logic [OUT_W-1:0]  w_sig_step;

    // Rotate left by one then fold in the sampled response.
    assign w_sig_step = {r_sig[OUT_W-2:0], r_sig[OUT_W-1]} ^ resp;
`endif

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_stim        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_cnt     <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_stim        <= w_stim;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err_cnt     <= w_err_cnt;
            r_first_idx   <= w_first_idx;
            r_first_valid <= w_first_valid;
        end
    end

`ifdef SWEEP_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else begin
            r_sig <= w_sig;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_stim        = r_stim;
        w_busy        = r_busy;
        w_done        = r_done;
        w_err_cnt     = r_err_cnt;
        w_first_idx   = r_first_idx;
        w_first_valid = r_first_valid;
`ifdef SWEEP_SIGNATURE_EN
        w_sig         = r_sig;
`endif

        case (r_state)
            // A new sweep can be launched from IDLE or after a completed
            // sweep; every result register is cleared at the same edge.
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state       = S_APPLY;
                    w_cnt         = c_settle_ld;
                    w_stim        = '0;
                    w_busy        = 1'b1;
                    w_done        = 1'b0;
                    w_err_cnt     = '0;
                    w_first_idx   = '0;
                    w_first_valid = 1'b0;
`ifdef SWEEP_SIGNATURE_EN
                    w_sig         = '0;
`endif
                end
            end

            // Hold the code while the DUT and golden model settle.
            S_APPLY: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_CHECK;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end

            // Single-cycle sample of resp/exp for the current code.
            S_CHECK: begin
                if (w_mismatch) begin
                    // At most 2^IN_W codes are checked per sweep, so the
                    // IN_W+1 bit counter cannot overflow.
                    w_err_cnt = r_err_cnt + c_err_one;
                    if (!r_first_valid) begin
                        w_first_idx   = r_stim;
                        w_first_valid = 1'b1;
                    end
                end
`ifdef SWEEP_SIGNATURE_EN
                w_sig = w_sig_step;
`endif
                if (r_stim == c_max_code) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_APPLY;
                    w_stim  = r_stim + c_stim_one;
                    w_cnt   = c_settle_ld;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign stim            = r_stim;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err_cnt         = r_err_cnt;
    assign first_err_idx   = r_first_idx;
    assign first_err_valid = r_first_valid;

`ifdef SWEEP_SIGNATURE_EN
    assign sig = r_sig;
`else
    assign sig = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Purpose  : Directed self-checking bench for truth_table_sweeper with
//            IN_W=3, OUT_W=4, SETTLE=1. The DUT response is stim+1; the
//            golden-model input is derived from it per test mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    localparam int IN_W  = 3;
    localparam int OUT_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [IN_W-1:0]   stim;
    logic [OUT_W-1:0]  resp;
    logic [OUT_W-1:0]  exp_v;
    logic              busy;
    logic              done;
    logic [IN_W:0]     err_cnt;
    logic [IN_W-1:0]   first_err_idx;
    logic              first_err_valid;
    logic [OUT_W-1:0]  sig;

    // 0: exp = resp, 1: exp differs only at code 5, 2: exp = ~resp
    int                mode;
    int                checks;
    int                failures;
    int                cyc;
    logic [OUT_W-1:0]  sig_expect;

    truth_table_sweeper #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SETTLE (1)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stim            (stim),
        .resp            (resp),
        .exp             (exp_v),
        .busy            (busy),
        .done            (done),
        .err_cnt         (err_cnt),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid),
        .sig             (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        resp = 4'(stim) + 4'd1;
        case (mode)
            1:       exp_v = (stim == 3'd5) ? (resp ^ 4'b0001) : resp;
            2:       exp_v = ~resp;
            default: exp_v = resp;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Leaves the bench at the negedge right after the start edge.
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts posedges (seen at following negedges) until done, bounded.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        rst      = 1'b1;
        start    = 1'b0;
        // resp=stim+1 for 0..7 rotate-XOR folds to 4'h7
`ifdef SWEEP_SIGNATURE_EN
        sig_expect = 4'h7;
`else
        sig_expect = 4'h0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_stim",  32'(stim), 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   32'(err_cnt), 32'd0);
        check("rst_fidx",  32'(first_err_idx), 32'd0);
        check("rst_fval",  {31'd0, first_err_valid}, 32'd0);
        check("rst_sig",   32'(sig), 32'd0);

        // Test 1: clean sweep, two cycles per code, done 16 cycles after start
        mode = 0;
        pulse_start;
        check("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_stim%0d", i), 32'(stim), 32'(i / 2));
            check($sformatf("t1_nodone%0d", i), {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check("t1_done",  {31'd0, done}, 32'd1);
        check("t1_busy0", {31'd0, busy}, 32'd0);
        check("t1_stimmax", 32'(stim), 32'd7);
        check("t1_err",   32'(err_cnt), 32'd0);
        check("t1_fval",  {31'd0, first_err_valid}, 32'd0);
        check("t1_sig",   32'(sig), 32'(sig_expect));
        @(negedge clk);
        check("t1_done_held", {31'd0, done}, 32'd1);

        // Test 2: single mismatch at code 5
        mode = 1;
        pulse_start;
        wait_done(0, cyc);
        check("t2_cycles", 32'(cyc), 32'd16);
        check("t2_err",  32'(err_cnt), 32'd1);
        check("t2_fidx", 32'(first_err_idx), 32'd5);
        check("t2_fval", {31'd0, first_err_valid}, 32'd1);

        // Test 3: every code mismatches, counter reaches 8 without wrap
        mode = 2;
        pulse_start;
        wait_done(0, cyc);
        check("t3_err",  32'(err_cnt), 32'd8);
        check("t3_fidx", 32'(first_err_idx), 32'd0);
        check("t3_fval", {31'd0, first_err_valid}, 32'd1);
        check("t3_sig",  32'(sig), 32'(sig_expect));

        // Test 5b: start in DONE clears results and restarts at 0
        mode = 0;
        pulse_start;
        check("t5b_done0", {31'd0, done}, 32'd0);
        check("t5b_err0",  32'(err_cnt), 32'd0);
        check("t5b_fval0", {31'd0, first_err_valid}, 32'd0);
        check("t5b_busy",  {31'd0, busy}, 32'd1);
        check("t5b_stim0", 32'(stim), 32'd0);
        wait_done(0, cyc);
        check("t5b_cycles", 32'(cyc), 32'd16);

        // Test 5a: start pulsed mid-sweep is ignored
        pulse_start;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5a_stim_mid", 32'(stim), 32'd2);
        wait_done(5, cyc);
        check("t5a_cycles", 32'(cyc), 32'd16);
        check("t5a_err", 32'(err_cnt), 32'd0);

        // Test 4: reset mid-sweep at stim=3 with errors accumulated
        mode = 2;
        pulse_start;
        cyc = 0;
        while (stim != 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_reach3", 32'(stim), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_stim", 32'(stim), 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_err",  32'(err_cnt), 32'd0);
        check("t4_fval", {31'd0, first_err_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_idle_stim", 32'(stim), 32'd0);
        mode = 0;
        pulse_start;
        check("t4_restart_stim", 32'(stim), 32'd0);
        wait_done(0, cyc);
        check("t4_cycles", 32'(cyc), 32'd16);
        check("t4_err_final", 32'(err_cnt), 32'd0);
        check("t4_sig", 32'(sig), 32'(sig_expect));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
